// File: rtl/s2f_sync_multi.sv
// Multi-channel slow-to-fast bit synchroniser with registered level, rise/fall pulses and sticky event flags.
// Define S2F_SYNC_FILTER_EN to add a per-channel stability filter of FILT_CYC cycles.
module s2f_sync_multi #(
    parameter int                CH_NUM      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CYC    = 3,
    parameter logic [CH_NUM-1:0] RST_VAL     = '0
) (
    input  logic              clka,
    input  logic              rst,
    input  logic [CH_NUM-1:0] din,
    output logic [CH_NUM-1:0] dout,
    output logic [CH_NUM-1:0] rise,
    output logic [CH_NUM-1:0] fall,
    output logic              any_edge,
    output logic [CH_NUM-1:0] evt_flag,
    input  logic [CH_NUM-1:0] evt_clr
);

    generate
        if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch_num
            $error("s2f_sync_multi: CH_NUM must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("s2f_sync_multi: SYNC_STAGES must be 2..4");
        end
        if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt_cyc
            $error("s2f_sync_multi: FILT_CYC must be 1..255");
        end
    endgenerate

    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] sync_out;
    logic [CH_NUM-1:0] sync_acc;

    // Plain flop chain: din touches only stage 0, nothing sits between stages.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef S2F_SYNC_FILTER_EN
    localparam int                CNT_W    = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [CNT_W-1:0]  filt_cnt [CH_NUM];
    logic [CH_NUM-1:0] accept;

    // A channel is accepted once its differing value has been seen for FILT_CYC cycles in a row.
    always_comb begin
        accept   = '0;
        sync_acc = dout;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            accept[ch] = (sync_out[ch] != dout[ch]) && (filt_cnt[ch] == CNT_LAST);
            if (accept[ch]) begin
                sync_acc[ch] = sync_out[ch];
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                filt_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if ((sync_out[ch] == dout[ch]) || accept[ch]) begin
                    filt_cnt[ch] <= '0;
                end else begin
                    filt_cnt[ch] <= filt_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign sync_acc = sync_out;
`endif

    // Edge pulses line up with the cycle in which dout first shows the new level.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            dout     <= RST_VAL;
            rise     <= '0;
            fall     <= '0;
            evt_flag <= '0;
        end else begin
            dout     <= sync_acc;
            rise     <= sync_acc & ~dout;
            fall     <= ~sync_acc & dout;
            evt_flag <= (evt_flag & ~evt_clr) | rise | fall;
        end
    end

    assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_s2f_sync_multi.sv
// Self-checking bench for s2f_sync_multi: directed scenarios plus random traffic against a history-based model.
// Honours S2F_SYNC_FILTER_EN so the same bench covers both builds.
module tb_s2f_sync_multi;

    localparam int                CH_NUM      = 4;
    localparam int                SYNC_STAGES = 2;
    localparam int                FILT_CYC    = 3;
    localparam logic [CH_NUM-1:0] RST_VAL     = '0;
`ifdef S2F_SYNC_FILTER_EN
    localparam int F_EFF = FILT_CYC;
`else
    localparam int F_EFF = 1;
`endif
    localparam int LAT = SYNC_STAGES + F_EFF - 1;

    logic              clka = 1'b0;
    logic              rst;
    logic [CH_NUM-1:0] din;
    logic [CH_NUM-1:0] dout;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic              any_edge;
    logic [CH_NUM-1:0] evt_flag;
    logic [CH_NUM-1:0] evt_clr;

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    s2f_sync_multi #(
        .CH_NUM     (CH_NUM),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYC   (FILT_CYC),
        .RST_VAL    (RST_VAL)
    ) dut (
        .clka    (clka),
        .rst     (rst),
        .din     (din),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .any_edge(any_edge),
        .evt_flag(evt_flag),
        .evt_clr (evt_clr)
    );

    // Reference model: din history since reset; a level is accepted once the last F_EFF synchronised samples all disagree with it.
    logic [CH_NUM-1:0] din_hist [$];
    logic [CH_NUM-1:0] m_dout, m_rise, m_fall, m_flag;

    function automatic logic [CH_NUM-1:0] sync_after(int e);
        int idx;
        idx = e - SYNC_STAGES + 1;
        if (idx >= 0 && idx < din_hist.size()) return din_hist[idx];
        return RST_VAL;
    endfunction

    function automatic logic [CH_NUM-1:0] next_dout();
        logic [CH_NUM-1:0] nd;
        logic [CH_NUM-1:0] s;
        int                n;
        bit                flip;
        nd = m_dout;
        n  = din_hist.size() - 1;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            flip = 1'b1;
            for (int j = 1; j <= F_EFF; j++) begin
                s = sync_after(n - j);
                if (s[ch] == m_dout[ch]) flip = 1'b0;
            end
            if (flip) nd[ch] = ~m_dout[ch];
        end
        return nd;
    endfunction

    function automatic logic [4*CH_NUM:0] model_vec();
        return {m_dout, m_rise, m_fall, |(m_rise | m_fall), m_flag};
    endfunction

    always @(posedge clka or posedge rst) begin
        if (rst) begin
            din_hist.delete();
            m_dout <= RST_VAL;
            m_rise <= '0;
            m_fall <= '0;
            m_flag <= '0;
        end else begin
            din_hist.push_back(din);
            m_dout <= next_dout();
            m_rise <= next_dout() & ~m_dout;
            m_fall <= ~next_dout() & m_dout;
            m_flag <= (m_flag & ~evt_clr) | m_rise | m_fall;
        end
    end

    task automatic test_reset();
        rst     = 1'b1;
        din     = '0;
        evt_clr = '0;
        repeat (3) @(negedge clka);
        checks++;
        if ({dout, rise, fall, any_edge, evt_flag} !== {RST_VAL, {(3*CH_NUM+1){1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_state got %h exp %h", {dout, rise, fall, any_edge, evt_flag},
                     {RST_VAL, {(3*CH_NUM+1){1'b0}}});
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [CH_NUM+1:0] got;
        logic [CH_NUM+1:0] exp;
        @(negedge clka);
        din = 4'b0001;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clka);
            got = {dout[0], rise[0], any_edge, evt_flag[CH_NUM-2:0]};
            exp = {c > LAT, c == LAT + 1, c == LAT + 1, (c > LAT + 1) ? 3'b001 : 3'b000};
            checks++;
            if (got !== exp || evt_flag[CH_NUM-1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency cyc=%0d got %b flag %b exp %b", c, got, evt_flag, exp);
            end
            checks++;
            if ({dout, rise, fall, any_edge, evt_flag} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL latency_model cyc=%0d got %h exp %h", c,
                         {dout, rise, fall, any_edge, evt_flag}, model_vec());
            end
        end
    endtask

    task automatic test_depth();
        int rise_at = -1, fall_at = -1, n_rise = 0, n_fall = 0;
        din = '0;
        repeat (LAT + 3) @(negedge clka);
        din[2] = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clka);
            if (rise[2]) begin rise_at = c; n_rise++; end
            if (fall[2]) begin fall_at = c; n_fall++; end
            checks++;
            if ({dout, rise, fall, any_edge, evt_flag} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL depth_model cyc=%0d got %h exp %h", c,
                         {dout, rise, fall, any_edge, evt_flag}, model_vec());
            end
            if (c == 10) din[2] = 1'b0;
        end
        checks++;
        if (rise_at !== LAT + 1 || n_rise !== 1) begin
            errors++;
            $display("[TB] FAIL depth_rise at=%0d count=%0d exp at=%0d count=1", rise_at, n_rise, LAT + 1);
        end
        checks++;
        if (fall_at !== 10 + LAT + 1 || n_fall !== 1) begin
            errors++;
            $display("[TB] FAIL depth_fall at=%0d count=%0d exp at=%0d count=1", fall_at, n_fall, 10 + LAT + 1);
        end
    endtask

    task automatic test_filter();
        int n_rise = 0, rise_at = -1;
        int exp_glitch_rise;
        exp_glitch_rise = (2 >= F_EFF) ? 1 : 0;
        din = '0;
        repeat (LAT + 3) @(negedge clka);
        din[1] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clka);
            if (c == 2) din[1] = 1'b0;
            if (rise[1]) n_rise++;
            checks++;
            if ({dout, rise, fall, any_edge, evt_flag} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL filter_glitch_model cyc=%0d got %h exp %h", c,
                         {dout, rise, fall, any_edge, evt_flag}, model_vec());
            end
        end
        checks++;
        if (n_rise !== exp_glitch_rise) begin
            errors++;
            $display("[TB] FAIL filter_glitch rises=%0d exp %0d", n_rise, exp_glitch_rise);
        end
        n_rise = 0;
        din[1] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clka);
            if (c == 6) din[1] = 1'b0;
            if (rise[1]) begin n_rise++; rise_at = c; end
        end
        checks++;
        if (n_rise !== 1 || rise_at !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL filter_long rises=%0d at=%0d exp 1 at=%0d", n_rise, rise_at, LAT + 1);
        end
    endtask

    task automatic test_sticky_clear();
        bit seen;
        din[3] = 1'b1;
        repeat (LAT + 3) @(negedge clka);
        evt_clr = '1;
        @(negedge clka);
        evt_clr = '0;
        din[3]  = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < LAT + 6 && !seen; c++) begin
            @(negedge clka);
            if (fall[3]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL sticky_fall_timeout got none exp fall[3]");
        end
        @(negedge clka);
        checks++;
        if (evt_flag[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky_set got %b exp 1", evt_flag[3]);
        end
        evt_clr[3] = 1'b1;
        @(negedge clka);
        checks++;
        if (evt_flag[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sticky_clear got %b exp 0", evt_flag[3]);
        end
        evt_clr[3] = 1'b0;
        din[3]     = 1'b1;
        seen       = 1'b0;
        for (int c = 0; c < LAT + 6 && !seen; c++) begin
            @(negedge clka);
            if (rise[3]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL sticky_rise_timeout got none exp rise[3]");
        end
        evt_clr[3] = 1'b1;
        @(negedge clka);
        checks++;
        if (evt_flag[3] !== 1'b1 || evt_flag !== m_flag) begin
            errors++;
            $display("[TB] FAIL set_wins got %b exp %b", evt_flag, m_flag);
        end
        evt_clr[3] = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit seen = 1'b0;
        din = '0;
        repeat (LAT + 3) @(negedge clka);
        evt_clr = '1;
        @(negedge clka);
        evt_clr = '0;
        din     = 4'b1111;
        for (int c = 0; c < LAT + 6 && !seen; c++) begin
            @(negedge clka);
            if (rise !== '0) seen = 1'b1;
        end
        checks++;
        if (rise !== 4'b1111 || any_edge !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_rise got %b/%b exp 1111/1", rise, any_edge);
        end
        @(negedge clka);
        checks++;
        if (any_edge !== 1'b0 || evt_flag !== 4'b1111 || dout !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL simul_after any=%b flag=%b dout=%b exp 0/1111/1111", any_edge, evt_flag, dout);
        end
    endtask

    task automatic test_random();
        logic [CH_NUM-1:0] toggle;
        for (int c = 0; c < 400; c++) begin
            @(negedge clka);
            checks++;
            if ({dout, rise, fall, any_edge, evt_flag} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random_model cyc=%0d got %h exp %h", c,
                         {dout, rise, fall, any_edge, evt_flag}, model_vec());
            end
            for (int ch = 0; ch < CH_NUM; ch++) begin
                toggle[ch]  = ($urandom_range(0, 4) == 0);
                evt_clr[ch] = ($urandom_range(0, 3) == 0);
            end
            din = din ^ toggle;
        end
        evt_clr = '0;
    endtask

    task automatic test_midreset();
        logic [4*CH_NUM:0] exp;
        din = '0;
        repeat (LAT + 3) @(negedge clka);
        din = 4'b1010;
        @(posedge clka);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, rise, fall, any_edge, evt_flag} !== {RST_VAL, {(3*CH_NUM+1){1'b0}}}) begin
            errors++;
            $display("[TB] FAIL midreset_async got %h", {dout, rise, fall, any_edge, evt_flag});
        end
        repeat (2) @(negedge clka);
        checks++;
        if ({dout, rise, fall, any_edge} !== {RST_VAL, {(2*CH_NUM+1){1'b0}}}) begin
            errors++;
            $display("[TB] FAIL midreset_hold got %h", {dout, rise, fall, any_edge});
        end
        rst = 1'b0;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clka);
            exp = {(c > LAT) ? 4'b1010 : 4'b0000, (c == LAT + 1) ? 4'b1010 : 4'b0000, 4'b0000,
                   c == LAT + 1, (c > LAT + 1) ? 4'b1010 : 4'b0000};
            checks++;
            if ({dout, rise, fall, any_edge, evt_flag} !== exp || exp !== model_vec()) begin
                errors++;
                $display("[TB] FAIL midreset_release cyc=%0d got %h exp %h model %h", c,
                         {dout, rise, fall, any_edge, evt_flag}, exp, model_vec());
            end
        end
    endtask

    initial begin
        $display("[TB] s2f_sync_multi bench, SYNC_STAGES=%0d effective filter=%0d", SYNC_STAGES, F_EFF);
        test_reset();
        test_latency();
        test_depth();
        test_filter();
        test_sticky_clear();
        test_simultaneous();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2f_sync_multi.md
Name: s2f_sync_multi

Overview:
- Multi-channel slow-to-fast single-bit synchroniser. Successor to the fixed 2-flop, 1-bit synchroniser.
- Each of CH_NUM quasi-static or slow-domain bits is resynchronised into clka through a SYNC_STAGES-deep flop chain.
- Optional stability filter per channel (see Optional Feature).
- Registered level output plus one-cycle rise/fall pulses, and sticky per-channel event flags with software clear.
- Sits at the slow→fast boundary, feeding control/status logic in the clka domain.

Parameters:
- CH_NUM, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser chain depth (legal 2..4; elaboration error outside range).
- FILT_CYC, 3, consecutive clka cycles a new synchronised value must persist before acceptance (1..255; used only with filter compiled in).
- RST_VAL, 0, CH_NUM-bit reset value of the synchroniser chain and dout.

Ports:
- clka  in  1  destination (fast) clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  CH_NUM  asynchronous inputs from the slow domain, one bit per channel.
- dout  out  CH_NUM  synchronised (and filtered) level.
- rise  out  CH_NUM  one-clka-cycle pulse when dout goes 0→1.
- fall  out  CH_NUM  one-clka-cycle pulse when dout goes 1→0.
- any_edge  out  1  OR of all rise|fall bits.
- evt_flag  out  CH_NUM  sticky: set by rise or fall of that channel.
- evt_clr  in  CH_NUM  synchronous to clka; clears the matching evt_flag bit.

Behaviour:
- Reset (rst=1, asynchronous) sets:
  - all chain stages to RST_VAL and dout = RST_VAL;
  - rise = fall = 0, any_edge = 0, evt_flag = 0;
  - filter counters = 0.
- Chain:
  - Stage 0 samples din on each clka edge; stage i samples stage i-1.
  - sync_out = last stage.
  - No logic between chain stages; din feeds only stage 0.
- Update without filter: dout <= sync_out each cycle.
- Edges:
  - rise[i] <= sync_acc[i] & ~dout[i]; fall[i] <= ~sync_acc[i] & dout[i], where sync_acc is the value being loaded into dout.
  - rise/fall are therefore asserted in the same cycle dout shows the new value, for exactly one cycle.
- Latency: a din change stable before clka edge k appears on dout/rise/fall after edge k+SYNC_STAGES+FILT_CYC-1. Without the filter, FILT_CYC is treated as 1, giving SYNC_STAGES edges.
- any_edge: combinational OR of registered rise|fall (no extra latency).
- evt_flag[i]:
  - set on rise[i]|fall[i];
  - cleared when evt_clr[i]=1;
  - set and clear in the same cycle: set wins (flag stays 1);
  - evt_clr on a flag that is already 0 has no effect.
- Post-reset: if din ≠ RST_VAL when rst deasserts, the change propagates normally and produces the corresponding rise/fall and evt_flag.
- Channels are fully independent; simultaneous edges on several channels are all reported in the same cycle.
- din pulses shorter than one clka period may be lost. The required input contract: din holds each value ≥ 2 clka periods (≥ FILT_CYC+1 with filter).

Optional Feature:
- Macro: S2F_SYNC_FILTER_EN.
- Defined:
  - Per-channel counter of width clog2(FILT_CYC+1).
  - While sync_out[i] ≠ dout[i], the counter increments each cycle.
  - When the counter reaches FILT_CYC-1 and the values still differ, dout[i] is loaded, a rise/fall is generated, and the counter returns to 0.
  - If sync_out[i] == dout[i] at any point, the counter returns to 0 immediately.
  - Synchronised glitches shorter than FILT_CYC cycles never reach dout.
  - FILT_CYC=1 is equivalent to no filter.
- Undefined: no counters; dout <= sync_out every cycle; FILT_CYC ignored.

Test Plan:
- Reset/latency: CH_NUM=4, SYNC_STAGES=2, filter off, RST_VAL=0.
  - Hold rst 3 cycles → all outputs 0.
  - Release, set din=4'b0001 before edge k → dout[0]=1 and rise[0]=1 after edge k+2, rise[0]=0 next cycle, evt_flag=4'b0001, any_edge high one cycle.
- Depth sweep: SYNC_STAGES=3 and 4, din[2] 0→1→0 with 10-cycle hold → dout[2] delayed exactly 3 and 4 edges; one rise then one fall pulse.
- Filter: S2F_SYNC_FILTER_EN defined, FILT_CYC=3.
  - din[1] high for 2 cycles → dout[1] stays 0, no rise.
  - din[1] high for 6 cycles → dout[1]=1 after edge k+4; single rise[1].
- Sticky/clear:
  - Generate fall[3], then hold evt_clr[3]=1 → evt_flag[3] clears next edge.
  - evt_clr[3]=1 in the same cycle as a new rise[3] → evt_flag[3] remains 1.
- Simultaneous: din 4'b0000→4'b1111 → rise=4'b1111 in one cycle, any_edge single pulse, evt_flag=4'b1111.
- Mid-operation reset: assert rst asynchronously while din=4'b1010 propagates through the chain → outputs return to RST_VAL immediately, with no rise/fall pulse during or on release. After release, dout=4'b1010 after SYNC_STAGES edges with matching rise pulses.
